// File: rtl/bp_pkg.sv
// Shared branch-predictor types and helpers: PHT geometry, counter encoding and the
// saturating counter update used by both the gshare PHT and the tournament chooser.
package bp_pkg;

    localparam int GHR_W     = 12;
    localparam int PC_LSB    = 2;
    localparam int CTR_W     = 2;
    localparam int PHT_DEPTH = 2 ** GHR_W;

    typedef logic [CTR_W-1:0] ctr_t;
    typedef logic [GHR_W-1:0] pht_idx_t;

    localparam ctr_t CTR_SNT = ctr_t'(0);
    localparam ctr_t CTR_WNT = ctr_t'(1);
    localparam ctr_t CTR_WT  = ctr_t'(2);
    localparam ctr_t CTR_ST  = ctr_t'(3);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } pht_state_t;

    // Counters clamp at both ends so a long run of one outcome never flips the prediction.
    function automatic ctr_t sat_next(input ctr_t ctr, input logic taken);
        ctr_t res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr_t'(ctr + 1'b1);
        end else begin
            if (ctr != CTR_SNT) res = ctr_t'(ctr - 1'b1);
        end
        return res;
    endfunction

endpackage

// File: rtl/gshare_pht_if.sv
// Predict/update port bundle of the gshare PHT. The master is the fetch/resolve side,
// the slave is the table itself.
interface gshare_pht_if;
    import bp_pkg::*;

    pht_idx_t    ghr_i;
    logic        pred_req_i;
    logic [31:0] pred_pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    pht_idx_t    pred_idx_o;
    logic        upd_valid_i;
    pht_idx_t    upd_idx_i;
    logic        upd_taken_i;
    logic        ready_o;

    modport master (
        output ghr_i, pred_req_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i,
        input  pred_valid_o, pred_taken_o, pred_idx_o, ready_o
    );

    modport slave (
        input  ghr_i, pred_req_i, pred_pc_i, upd_valid_i, upd_idx_i, upd_taken_i,
        output pred_valid_o, pred_taken_o, pred_idx_o, ready_o
    );

endinterface

// File: rtl/gshare_pht.sv
// Gshare pattern history table: 2^GHR_W saturating counters indexed by ghr ^ PC, with an
// init sweep after reset. Define GSHARE_PHT_BYPASS_EN to forward same-cycle updates into the prediction.
module gshare_pht
    import bp_pkg::*;
#(
    parameter ctr_t CTR_INIT = CTR_WNT
) (
    input  logic        clk,
    input  logic        rst,
    gshare_pht_if.slave pif
);

    localparam pht_idx_t IDX_LAST = pht_idx_t'(PHT_DEPTH - 1);

    ctr_t       mem [PHT_DEPTH];
    pht_state_t state_reg;
    pht_idx_t   init_ptr_reg;
    logic       pred_valid_reg;
    logic       pred_taken_reg;
    pht_idx_t   pred_idx_reg;

    logic       ready_st;
    pht_idx_t   req_idx;
    ctr_t       rd_ctr;
    ctr_t       upd_ctr;
    ctr_t       upd_next;
    ctr_t       pred_ctr;
    logic       wr_en;
    pht_idx_t   wr_idx;
    ctr_t       wr_data;
    logic       unused_pc_bits;

    assign ready_st       = (state_reg == ST_READY);
    assign unused_pc_bits = ^{pif.pred_pc_i[31:PC_LSB+GHR_W], pif.pred_pc_i[PC_LSB-1:0]};

    always_comb begin
        req_idx  = pif.ghr_i ^ pif.pred_pc_i[PC_LSB +: GHR_W];
        rd_ctr   = mem[req_idx];
        upd_ctr  = mem[pif.upd_idx_i];
        upd_next = sat_next(upd_ctr, pif.upd_taken_i);
        pred_ctr = rd_ctr;
`ifdef GSHARE_PHT_BYPASS_EN
        if (ready_st && pif.upd_valid_i && (pif.upd_idx_i == req_idx)) pred_ctr = upd_next;
`endif
        // The sweep owns the write port until the table is fully initialised.
        if (ready_st) begin
            wr_en   = pif.upd_valid_i;
            wr_idx  = pif.upd_idx_i;
            wr_data = upd_next;
        end else begin
            wr_en   = 1'b1;
            wr_idx  = init_ptr_reg;
            wr_data = CTR_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_INIT;
            init_ptr_reg   <= '0;
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_idx_reg   <= '0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    pred_valid_reg <= 1'b0;
                    init_ptr_reg   <= init_ptr_reg + 1'b1;
                    if (init_ptr_reg == IDX_LAST) state_reg <= ST_READY;
                end
                ST_READY: begin
                    pred_valid_reg <= pif.pred_req_i;
                    if (pif.pred_req_i) begin
                        pred_idx_reg   <= req_idx;
                        pred_taken_reg <= pred_ctr[CTR_W-1];
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign pif.ready_o      = ready_st;
    assign pif.pred_valid_o = pred_valid_reg;
    assign pif.pred_taken_o = pred_taken_reg;
    assign pif.pred_idx_o   = pred_idx_reg;

endmodule
